// File: rtl/sd_sector_responder.sv
// sd_sector_responder: serves 512-byte sector reads/writes (sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_*) from a byte-wide req/ack store
//   clk_sys, RESET_n : clock (posedge), asynchronous active-low reset
//   sd_lba/sd_rd/sd_wr : sector number and level requests, sampled in IDLE only
//   sd_ack             : high for the whole transfer of one sector
//   sd_buff_*          : requester buffer port (addr/dout/wr strobe out, din in with one cycle of RAM latency)
//   mem_*              : backing store port, mem_rd/mem_wr held until the one-cycle mem_ack
//   err                : sticky out-of-range flag, live only when SD_LBA_BOUNDS_EN is defined
module sd_sector_responder #(
  parameter int LBA_W = 32,
  parameter int MEM_AW = 24,
  parameter int IMG_SECTORS = 64
) (
  input  logic              clk_sys,
  input  logic              RESET_n,
  input  logic [LBA_W-1:0]  sd_lba,
  input  logic              sd_rd,
  input  logic              sd_wr,
  output logic              sd_ack,
  output logic [8:0]        sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  output logic              sd_buff_wr,
  input  logic [7:0]        sd_buff_din,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_dout,
  input  logic [7:0]        mem_din,
  input  logic              mem_ack,
  output logic              err
);
`ifdef SD_LBA_BOUNDS_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, ACK, RD_FETCH, RD_PUT, WR_ADDR, WR_WAIT, WR_STORE, DONE} state_t;
  state_t state, state_d;
  logic [LBA_W-1:0] lba, lba_d;
  logic [8:0] off, off_d, buff_addr_d;
  logic [7:0] buff_dout_d, mem_dout_d;
  logic rd_dir, rd_dir_d, oob, oob_d, err_d, ack_d, buff_wr_d, mem_rd_d, mem_wr_d;
  // {lba, off} equals lba*512 + off; the cast drops upper LBA bits so the image wraps
  assign mem_addr = MEM_AW'({lba, off});
  always_comb begin
    state_d = state;
    lba_d = lba;
    off_d = off;
    rd_dir_d = rd_dir;
    oob_d = oob;
    err_d = err;
    ack_d = sd_ack;
    buff_addr_d = sd_buff_addr;
    buff_dout_d = sd_buff_dout;
    buff_wr_d = 1'b0;
    mem_rd_d = mem_rd;
    mem_wr_d = mem_wr;
    mem_dout_d = mem_dout;
    case (state)
      IDLE: if (sd_rd || sd_wr) begin
        state_d = ACK;
        lba_d = sd_lba;
        rd_dir_d = sd_rd;
        oob_d = BOUNDS && ({1'b0, sd_lba} >= (LBA_W+1)'(IMG_SECTORS));
        err_d = err | oob_d;
      end
      ACK: begin
        ack_d = 1'b1;
        off_d = '0;
        buff_addr_d = '0;
        mem_rd_d = rd_dir && !oob;
        state_d = rd_dir ? RD_FETCH : WR_ADDR;
      end
      // out-of-range reads skip the store and deliver zeros at 2 cycles per byte
      RD_FETCH: if (oob || mem_ack) begin
        mem_rd_d = 1'b0;
        buff_dout_d = oob ? 8'h00 : mem_din;
        buff_addr_d = off;
        buff_wr_d = 1'b1;
        state_d = RD_PUT;
      end
      RD_PUT: if (&off) begin
        ack_d = 1'b0;
        state_d = DONE;
      end else begin
        off_d = off + 9'd1;
        mem_rd_d = !oob;
        state_d = RD_FETCH;
      end
      WR_ADDR: state_d = WR_WAIT;
      // buffer RAM data for the address set on entry to WR_ADDR is valid here
      WR_WAIT: begin
        mem_dout_d = sd_buff_din;
        mem_wr_d = !oob;
        state_d = WR_STORE;
      end
      WR_STORE: if (oob || mem_ack) begin
        mem_wr_d = 1'b0;
        ack_d = !(&off);
        off_d = (&off) ? off : off + 9'd1;
        buff_addr_d = (&off) ? off : off + 9'd1;
        state_d = (&off) ? DONE : WR_ADDR;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_sys or negedge RESET_n)
    if (!RESET_n) begin
      state <= IDLE;
      lba <= '0;
      off <= '0;
      rd_dir <= 1'b0;
      oob <= 1'b0;
      err <= 1'b0;
      sd_ack <= 1'b0;
      sd_buff_addr <= '0;
      sd_buff_dout <= '0;
      sd_buff_wr <= 1'b0;
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      mem_dout <= '0;
    end else begin
      state <= state_d;
      lba <= lba_d;
      off <= off_d;
      rd_dir <= rd_dir_d;
      oob <= oob_d;
      err <= err_d;
      sd_ack <= ack_d;
      sd_buff_addr <= buff_addr_d;
      sd_buff_dout <= buff_dout_d;
      sd_buff_wr <= buff_wr_d;
      mem_rd <= mem_rd_d;
      mem_wr <= mem_wr_d;
      mem_dout <= mem_dout_d;
    end
endmodule

// File: tb/tb_sd_sector_responder.sv
// tb_sd_sector_responder: randomized scoreboard bench for sd_sector_responder
module tb_sd_sector_responder;
  localparam int LBA_W = 32;
  localparam int MEM_AW = 24;
  localparam int IMG_SECTORS = 64;
  logic clk_sys = 1'b0;
  logic RESET_n = 1'b0;
  logic [LBA_W-1:0] sd_lba = '0;
  logic sd_rd = 1'b0;
  logic sd_wr = 1'b0;
  logic sd_ack;
  logic [8:0] sd_buff_addr;
  logic [7:0] sd_buff_dout;
  logic sd_buff_wr;
  logic [7:0] sd_buff_din = '0;
  logic [MEM_AW-1:0] mem_addr;
  logic mem_rd;
  logic mem_wr;
  logic [7:0] mem_dout;
  logic [7:0] mem_din = '0;
  logic mem_ack = 1'b0;
  logic err;
  int tests = 0;
  int fails = 0;
  int lat_max = 1;
  int buff_wr_cnt = 0;
  int mem_wr_cnt = 0;
  int mem_rd_cnt = 0;
  int ack_rises = 0;
  logic [7:0] phys [longint unsigned];
  logic [7:0] ref_store [longint unsigned];
  logic [7:0] rbuf [512];
  logic [16:0] exp_rd [$];
  logic [MEM_AW+7:0] exp_wr [$];

  sd_sector_responder #(.LBA_W(LBA_W), .MEM_AW(MEM_AW), .IMG_SECTORS(IMG_SECTORS)) dut (
    .clk_sys(clk_sys), .RESET_n(RESET_n), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
    .sd_buff_din(sd_buff_din), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_dout(mem_dout), .mem_din(mem_din), .mem_ack(mem_ack), .err(err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic flag(input string name, input logic [63:0] got);
    tests++;
    fails++;
    $display("FAIL %s: got %0h, expected nothing", name, got);
  endtask

  // untouched store bytes hold addr[7:0] ^ 5A
  function automatic logic [7:0] ref_byte(input longint unsigned a);
    return ref_store.exists(a) ? ref_store[a] : (8'(a) ^ 8'h5A);
  endfunction

  function automatic logic [7:0] phys_byte(input longint unsigned a);
    return phys.exists(a) ? phys[a] : (8'(a) ^ 8'h5A);
  endfunction

  // backing store: random ack latency 1..lat_max, one-cycle ack
  initial begin : mem_model
    int cnt;
    bit busy;
    cnt = 0;
    busy = 1'b0;
    forever begin
      @(posedge clk_sys);
      #1;
      if (!RESET_n || mem_ack) begin
        mem_ack = 1'b0;
        busy = 1'b0;
      end else if (mem_rd || mem_wr) begin
        if (!busy) begin
          busy = 1'b1;
          cnt = int'($urandom_range(1, lat_max)) - 1;
        end else cnt--;
        if (cnt == 0) begin
          mem_ack = 1'b1;
          if (mem_rd) mem_din = phys_byte(longint'(mem_addr));
          else phys[longint'(mem_addr)] = mem_dout;
        end
      end
    end
  end

  // requester buffer: synchronous RAM, data one cycle after the address
  initial begin : buf_model
    logic [8:0] a;
    forever begin
      @(negedge clk_sys);
      a = sd_buff_addr;
      @(posedge clk_sys);
      #1;
      sd_buff_din = rbuf[a];
    end
  end

  initial begin : monitor
    logic [16:0] er;
    logic [MEM_AW+7:0] ew;
    logic prev_ack;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (sd_ack && !prev_ack) ack_rises++;
      prev_ack = sd_ack;
      if (mem_rd && mem_wr) flag("mem_rd_and_mem_wr", {mem_rd, mem_wr});
      if (mem_rd) mem_rd_cnt++;
      if (sd_buff_wr) begin
        buff_wr_cnt++;
        if (exp_rd.size() == 0) flag("buff_wr_unexpected", {sd_buff_addr, sd_buff_dout});
        else begin
          er = exp_rd.pop_front();
          check("buff_wr addr/data", {sd_buff_addr, sd_buff_dout}, er);
        end
      end
      if (mem_wr && mem_ack) begin
        mem_wr_cnt++;
        if (exp_wr.size() == 0) flag("mem_wr_unexpected", {mem_addr, mem_dout});
        else begin
          ew = exp_wr.pop_front();
          check("mem_wr addr/data", {mem_addr, mem_dout}, ew);
        end
      end
    end
  end

  task automatic push_expect(input bit rd, input bit wr, input logic [LBA_W-1:0] lba, output bit oob);
    longint unsigned a;
    oob = 1'b0;
`ifdef SD_LBA_BOUNDS_EN
    oob = lba >= IMG_SECTORS;
`endif
    for (int k = 0; k < 512; k++) begin
      a = (longint'(lba) * 512 + longint'(k)) % (longint'(1) << MEM_AW);
      if (rd) exp_rd.push_back({9'(k), oob ? 8'h00 : ref_byte(a)});
      else if (wr && !oob) begin
        exp_wr.push_back({MEM_AW'(a), rbuf[k]});
        ref_store[a] = rbuf[k];
      end
    end
  endtask

  task automatic xfer(input bit rd, input bit wr, input logic [LBA_W-1:0] lba, input bit b2b);
    int n;
    bit oob;
    if (!b2b) begin
      repeat (2) @(posedge clk_sys);
      #1;
    end
    buff_wr_cnt = 0;
    mem_wr_cnt = 0;
    mem_rd_cnt = 0;
    push_expect(rd, wr, lba, oob);
    sd_lba = lba;
    sd_rd = rd;
    sd_wr = wr;
    n = 0;
    do begin
      @(posedge clk_sys);
      #1;
      n++;
    end while (!sd_ack && n < 10);
    sd_rd = 1'b0;
    sd_wr = 1'b0;
    check("ack_rise_latency", n, b2b ? 3 : 2);
    n = 0;
    while (sd_ack && n < 20000) begin
      @(posedge clk_sys);
      #1;
      n++;
    end
    check("ack_fall_timeout", sd_ack, 0);
    check("rd_queue_left", exp_rd.size(), 0);
    check("wr_queue_left", exp_wr.size(), 0);
    check("buff_wr_count", buff_wr_cnt, rd ? 512 : 0);
    check("mem_wr_count", mem_wr_cnt, (!rd && wr && !oob) ? 512 : 0);
    exp_rd.delete();
    exp_wr.delete();
  endtask

  task automatic check_reset(input string tag);
    check({tag, " sd_ack"}, sd_ack, 0);
    check({tag, " sd_buff_addr"}, sd_buff_addr, 0);
    check({tag, " sd_buff_dout"}, sd_buff_dout, 0);
    check({tag, " sd_buff_wr"}, sd_buff_wr, 0);
    check({tag, " mem_rd"}, mem_rd, 0);
    check({tag, " mem_wr"}, mem_wr, 0);
    check({tag, " mem_addr"}, mem_addr, 0);
    check({tag, " mem_dout"}, mem_dout, 0);
    check({tag, " err"}, err, 0);
  endtask

  initial begin
    int n, bad, r0;
    bit oob;
    logic [LBA_W-1:0] lba;
    bit rd;
    for (int k = 0; k < 512; k++) rbuf[k] = ~8'(k);
    repeat (3) @(posedge clk_sys);
    #1;
    check_reset("reset");
    RESET_n = 1'b1;
    lat_max = 1;
    xfer(1'b1, 1'b0, 3, 1'b0);
    lat_max = 5;
    xfer(1'b0, 1'b1, 1, 1'b0);
    bad = 0;
    for (int k = 0; k < 512; k++) if (phys_byte(longint'(512 + k)) !== ~8'(k)) bad++;
    check("store_sector1_bad_bytes", bad, 0);
    lat_max = 1;
    r0 = ack_rises;
    for (int l = 0; l < 64; l++) xfer(1'b1, 1'b0, l, l != 0);
    check("loop_ack_rises", ack_rises - r0, 64);
    xfer(1'b1, 1'b1, 0, 1'b0);
    // reset in the middle of a read, then restart from offset 0
    repeat (2) @(posedge clk_sys);
    #1;
    push_expect(1'b1, 1'b0, 5, oob);
    sd_lba = 5;
    sd_rd = 1'b1;
    n = 0;
    do begin
      @(posedge clk_sys);
      #1;
      n++;
      if (sd_ack) sd_rd = 1'b0;
    end while (!(sd_buff_wr && sd_buff_addr == 9'd200) && n < 2000);
    sd_rd = 1'b0;
    check("reached_offset_200", sd_buff_addr, 200);
    RESET_n = 1'b0;
    #1;
    exp_rd.delete();
    check_reset("mid_reset");
    @(posedge clk_sys);
    #1;
    RESET_n = 1'b1;
    xfer(1'b1, 1'b0, 5, 1'b0);
`ifdef SD_LBA_BOUNDS_EN
    xfer(1'b1, 1'b0, 64, 1'b0);
    check("oob_err", err, 1);
    check("oob_mem_rd_cycles", mem_rd_cnt, 0);
    xfer(1'b0, 1'b1, 70, 1'b0);
    check("oob_err_sticky", err, 1);
`else
    xfer(1'b1, 1'b0, 32'h0000_8002, 1'b0);
    check("err_tied_low", err, 0);
`endif
    lat_max = 3;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 512; k++) rbuf[k] = 8'($urandom);
      rd = 1'($urandom_range(0, 1));
      lba = ($urandom_range(0, 3) == 0) ? LBA_W'($urandom) : LBA_W'($urandom_range(0, 63));
      xfer(rd, !rd || 1'($urandom_range(0, 1)), lba, 1'b0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sd_sector_responder.md
Name: sd_sector_responder

Overview:
- Responder end of the sector-transfer handshake used by the backup-RAM save/load logic (sd_lba / sd_rd / sd_wr / sd_ack / sd_buff_*).
- Serves 512-byte sector requests from a byte-wide backing store behind a req/ack memory port.
- Read requests stream the sector into the requester's buffer.
- Write requests pull the sector out of the requester's buffer.
- Sits where hps_io's sector engine sits. Used in simulation and for on-chip save images, so a core's backup logic runs without the HPS.

Parameters:
- LBA_W, 32, width of sd_lba.
- MEM_AW, 24, backing-store byte address width; address = {lba, 9'b0} + offset, truncated to MEM_AW.
- IMG_SECTORS, 64, number of sectors in the image (used only with SD_LBA_BOUNDS_EN).

Ports:
- clk_sys  in  1  system clock; all logic on posedge.
- RESET_n  in  1  asynchronous active-low reset.
- sd_lba  in  LBA_W  sector number; sampled when a request is accepted.
- sd_rd  in  1  read request (level).
- sd_wr  in  1  write request (level).
- sd_ack  out  1  high for the whole transfer of one sector.
- sd_buff_addr  out  9  byte offset within the sector.
- sd_buff_dout  out  8  read data to the requester's buffer.
- sd_buff_wr  out  1  one-cycle write strobe for sd_buff_dout at sd_buff_addr.
- sd_buff_din  in  8  write data from the requester's buffer; valid 1 cycle after sd_buff_addr changes (synchronous RAM).
- mem_addr  out  MEM_AW  backing-store address.
- mem_rd  out  1  read request; held until mem_ack.
- mem_wr  out  1  write request; held until mem_ack.
- mem_dout  out  8  write data to the store.
- mem_din  in  8  read data; valid in the mem_ack cycle.
- mem_ack  in  1  one-cycle completion pulse; any latency of at least 1 cycle.
- err  out  1  sticky out-of-range flag (feature only; tied 0 otherwise).

Behaviour:
- Reset values: sd_ack=0, sd_buff_addr=0, sd_buff_dout=0, sd_buff_wr=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_dout=0, err=0, state=IDLE.
- A RESET_n assertion mid-transfer aborts at once. No partial sector is completed after release.
- State IDLE:
  - If sd_rd=1, latch sd_lba, set dir=READ, go to ACK.
  - Else if sd_wr=1, latch sd_lba, set dir=WRITE, go to ACK.
  - sd_rd has priority when both are high.
- State ACK:
  - sd_ack is driven high, registered; it rises exactly 1 cycle after acceptance.
  - Offset is cleared to 0.
  - Go to RD_FETCH or WR_ADDR.
  - Requests must drop after the sd_ack rise. Level on sd_rd/sd_wr is ignored until IDLE.
- Read path:
  - RD_FETCH: drive mem_rd=1 and mem_addr={lba,offset}. Wait for mem_ack.
  - On mem_ack: drop mem_rd, register mem_din into sd_buff_dout, set sd_buff_addr=offset, go to RD_PUT.
  - RD_PUT: sd_buff_wr=1 for exactly this one cycle.
  - If offset=511, go to DONE; else offset+1 and return to RD_FETCH.
- Write path:
  - WR_ADDR: drive sd_buff_addr=offset.
  - WR_WAIT: one cycle for buffer RAM latency.
  - WR_STORE: capture sd_buff_din into mem_dout; mem_wr=1 until mem_ack.
  - On mem_ack: if offset=511 go to DONE; else offset+1 and return to WR_ADDR.
- State DONE:
  - sd_ack falls. sd_buff_addr stays at 511.
  - Go to IDLE the next cycle.
  - Earliest next acceptance is 2 cycles after sd_ack falls. The requester re-raises sd_rd/sd_wr after detecting the falling edge.
- Ordering and width rules:
  - Exactly 512 sd_buff_wr pulses per read sector, at offsets 0..511 in ascending order.
  - Exactly 512 mem_wr transactions per write sector, in ascending order.
  - sd_buff_wr never asserts during a write transfer.
  - The offset counter is 9 bits. Wrap 511→0 is never used; the transfer ends instead.
  - mem_addr = ({lba,9'b0} + offset)[MEM_AW-1:0]. Upper LBA bits silently wrap.
- mem_rd and mem_wr are never high together. A mem_ack with no request outstanding is ignored.

Optional Feature:
- Macro: SD_LBA_BOUNDS_EN.
- Defined: at acceptance, if lba >= IMG_SECTORS, set err (sticky until reset) and run the normal handshake with no memory access:
  - Reads deliver 512 bytes of 8'h00 with the normal sd_buff_wr sequence, 1 byte per 2 cycles.
  - Writes are discarded; sd_buff_addr still sweeps 0..511.
- Undefined: no bounds check, err tied 0, address wraps per the width rule.

Test Plan:
- Store preloaded with byte = addr[7:0] ^ 8'h5A, mem_ack latency 1. Pulse sd_rd with sd_lba=3 → sd_ack high 1 cycle after acceptance; 512 sd_buff_wr pulses; byte at offset k = (1536+k)[7:0] ^ 8'h5A; sd_ack falls after offset 511.
- Requester buffer holds byte k = ~k[7:0], random mem_ack latency 1–5. Pulse sd_wr with sd_lba=1 → store bytes 512..1023 = ~k; zero sd_buff_wr pulses; mem_wr count = 512.
- Full 64-sector read loop with re-request on the sd_ack falling edge → 64 transfers, sd_lba 0..63; no missed or double acceptance.
- sd_rd and sd_wr high together with lba=0 → read performed, store unchanged.
- RESET_n low at offset 200 of a read → all outputs at reset values immediately; a new sd_rd after release restarts at offset 0.
- With SD_LBA_BOUNDS_EN and IMG_SECTORS=64, sd_rd with lba=64 → err=1; 512 zero bytes delivered; mem_rd never asserted.
